// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Fixed 34-cycle latency: PREP, 32 ITER steps, then FIX writes HI/LO.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
    state_t state, state_next;
    logic [1:0]  op_q;
    logic [31:0] rs_q, rt_q, mag_a, mag_b, abs_a, abs_b;
    logic        neg_q, neg_r, is_div, is_signed, sgn_a, sgn_b;
    logic [63:0] acc, prod_fix;
    logic [32:0] rem, mul_sum;
    logic [33:0] div_shift, div_trial;
    logic [31:0] quo_fix, rem_fix;
    logic [5:0]  cnt;
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign sgn_a     = is_signed & rs_q[31];
    assign sgn_b     = is_signed & rt_q[31];
    assign abs_a     = sgn_a ? -rs_q : rs_q;
    assign abs_b     = sgn_b ? -rt_q : rt_q;
    // Multiply: add multiplicand into the upper half, shift the whole accumulator right.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    // Divide: dividend bits shift out of acc[31] into the remainder; quotient bits shift in at acc[0].
    assign div_shift = {rem, acc[31]};
    assign div_trial = div_shift - {2'b00, mag_b};
    assign prod_fix  = neg_q ? -acc : acc;
    assign quo_fix   = neg_q ? -acc[31:0] : acc[31:0];
    assign rem_fix   = neg_r ? -rem[31:0] : rem[31:0];
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? PREP : IDLE;
            PREP:    state_next = ITER;
            ITER:    state_next = (cnt == 6'd31) ? FIX : ITER;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= state_next != IDLE;
            done  <= state == FIX;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 2'b00;
            rs_q  <= 32'd0;
            rt_q  <= 32'd0;
            mag_a <= 32'd0;
            mag_b <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc   <= 64'd0;
            rem   <= 33'd0;
            cnt   <= 6'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        rs_q <= rs_val;
                        rt_q <= rt_val;
                    end else begin
                        if (mthi) hi <= wr_data;
                        if (mtlo) lo <= wr_data;
                    end
                end
                PREP: begin
                    mag_a <= abs_a;
                    mag_b <= abs_b;
                    neg_q <= sgn_a ^ sgn_b;
                    neg_r <= sgn_a;
                    acc   <= {32'd0, is_div ? abs_a : abs_b};
                    rem   <= 33'd0;
                    cnt   <= 6'd0;
                end
                ITER: begin
                    cnt <= cnt + 6'd1;
                    if (is_div) begin
                        rem <= div_trial[33] ? div_shift[32:0] : div_trial[32:0];
                        acc <= {acc[62:0], ~div_trial[33]};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                end
                FIX: begin
                    // Divide by zero reports the original dividend, not a sign-fixed magnitude.
                    if (is_div && rt_q == 32'd0) begin
                        hi <= rs_q;
                        lo <= 32'hFFFF_FFFF;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed vectors.
// Stimulus pushes expected HI/LO; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;
    typedef struct {
        string       nm;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: hi=%h lo=%h with no pending result", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (hi !== e.h || lo !== e.l) begin
                    miscompares++;
                    $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", e.nm, hi, lo, e.h, e.l);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // kind: 0 plain, 1 mtlo mid-ITER, 2 second start mid-ITER, 3 mtlo with start
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string nm, input int kind);
        int n, nb;
        exp_t e;
        e.nm = nm;
        e.h = eh;
        e.l = el;
        sb.push_back(e);
        start = 1'b1;
        op = o;
        rs_val = a;
        rt_val = b;
        if (kind == 3) begin
            mtlo = 1'b1;
            wr_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        mtlo = 1'b0;
        n = 0;
        nb = 0;
        if (kind == 3) check({nm, "_lo_hold"}, lo, m_lo);
        while (!done && n < 40) begin
            if (busy) nb++;
            if (kind == 1 && n == 6) begin
                mtlo = 1'b1;
                wr_data = 32'hDEAD_BEEF;
            end
            if (kind == 2 && n == 11) begin
                start = 1'b1;
                op = 2'b01;
                rs_val = 32'd100;
                rt_val = 32'd200;
            end
            @(negedge clk);
            n++;
            if (kind == 1 && n == 7) begin
                mtlo = 1'b0;
                check({nm, "_lo_busy"}, lo, m_lo);
            end
            if (kind == 2 && n == 12) start = 1'b0;
        end
        check({nm, "_latency"}, 32'(n), 32'd34);
        check({nm, "_busy_cycles"}, 32'(nb), 32'd34);
        check({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
        run(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 0);
        run(2'b00, 32'd0, 32'h8000_0000, 32'd0, 32'd0, "mult_zero", 0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
        run(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, "divu_small", 0);
        run(2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, "divu_max", 0);
        run(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero", 0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf", 0);
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_neg_divisor", 0);
        run(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_by_zero", 0);
        mthi = 1'b1;
        wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", hi, 32'hCAFE_F00D);
        check("mthi_lo", lo, 32'hFFFF_FFFF);
        mthi = 1'b1;
        mtlo = 1'b1;
        wr_data = 32'h0BAD_F00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hi", hi, 32'h0BAD_F00D);
        check("mthilo_lo", lo, 32'h0BAD_F00D);
        m_hi = 32'h0BAD_F00D;
        m_lo = 32'h0BAD_F00D;
        run(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, "mtlo_busy", 1);
        run(2'b01, 32'd9, 32'd9, 32'd0, 32'd81, "start_busy", 2);
        run(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, "start_mtlo", 3);
        start = 1'b1;
        op = 2'b01;
        rs_val = 32'hFFFF_FFFF;
        rt_val = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        run(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_after_rst", 0);
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
